// File: rtl/diff_locator_seq_pkg.sv
// Shared definitions for the sequential first-difference locator.
package diff_locator_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_LSB = 1'b0;
   localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/chunk_prio_enc.sv
// Combinational priority encoder over one slice; dir selects lowest (LSB) or highest (MSB) set bit.
module chunk_prio_enc
   import diff_locator_seq_pkg::*;
#(
   parameter int CHUNK = 8,
   localparam int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
   input  logic [CHUNK-1:0] slice,
   input  logic             dir,
   output logic             any,
   output logic [OFF_W-1:0] offset
);

   // Later assignments win, so the loop direction picks the priority end.
   always_comb begin
      any    = |slice;
      offset = '0;
      if (dir == MODE_MSB) begin
         for (int i = 0; i < CHUNK; i++) begin
            if (slice[i]) offset = OFF_W'(i);
         end
      end else begin
         for (int i = CHUNK - 1; i >= 0; i--) begin
            if (slice[i]) offset = OFF_W'(i);
         end
      end
   end

endmodule

// File: rtl/diff_locator_seq.sv
// Multi-cycle first-difference locator: scans a^b one CHUNK-bit slice per cycle, stops at first hit.
module diff_locator_seq
   import diff_locator_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int NCHUNK = WIDTH / CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             msb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             found,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] onehot
);

   localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
      $error("diff_locator_seq: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   x_q;
   logic               mode_q;
   logic [CNT_W-1:0]   k_q;
   logic               found_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   onehot_q;

   logic [CNT_W-1:0]   sel;
   logic [CHUNK-1:0]   slice;
   logic               any;
   logic [OFF_W-1:0]   offset;
   logic [IDX_W-1:0]   hit_idx;
   logic               last;

   // MSB mode walks slices from the top down.
   assign sel     = (mode_q == MODE_LSB) ? k_q : CNT_W'(NCHUNK - 1) - k_q;
   assign last    = (k_q == CNT_W'(NCHUNK - 1));
   assign hit_idx = IDX_W'(int'(sel) * CHUNK + int'(offset));

   always_comb begin
      slice = '0;
      for (int c = 0; c < NCHUNK; c++) begin
         if (CNT_W'(c) == sel) slice = x_q[c*CHUNK +: CHUNK];
      end
   end

   chunk_prio_enc #(
      .CHUNK (CHUNK)
   ) u_enc (
      .slice  (slice),
      .dir    (mode_q),
      .any    (any),
      .offset (offset)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = SCAN;
         SCAN:    if (any || last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q      <= '0;
         mode_q   <= MODE_LSB;
         k_q      <= '0;
         found_q  <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
      end else if (state_q == IDLE) begin
         if (in_valid) begin
            x_q    <= a ^ b;
            mode_q <= msb_first;
            k_q    <= '0;
         end
      end else if (state_q == SCAN) begin
         if (any) begin
            found_q  <= 1'b1;
            idx_q    <= hit_idx;
            onehot_q <= WIDTH'(1) << hit_idx;
         end else if (last) begin
            found_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
         end else begin
            k_q <= k_q + CNT_W'(1);
         end
      end
   end

   assign found  = found_q;
   assign idx    = idx_q;
   assign onehot = onehot_q;

endmodule

// File: tb/tb_diff_locator_seq.sv
// Directed bench for diff_locator_seq at the default 32/8 configuration.
module tb_diff_locator_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        msb_first;
   logic        out_valid;
   logic        out_ready;
   logic        found;
   logic [4:0]  idx;
   logic [31:0] onehot;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   diff_locator_seq #(
      .WIDTH (32),
      .CHUNK (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .msb_first (msb_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .found     (found),
      .idx       (idx),
      .onehot    (onehot)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tm);
      chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
      a         = ta;
      b         = tb;
      msb_first = tm;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      msb_first = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 16) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
      chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
   endtask

   task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tm, input logic ef, input logic [4:0] eidx,
                      input logic [31:0] eoh, input int elat);
      int lat;
      send(tag, ta, tb, tm);
      wait_out(lat);
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk({tag, " found"}, 64'(found), 64'(ef));
      chk({tag, " idx"}, 64'(idx), 64'(eidx));
      chk({tag, " onehot"}, 64'(onehot), 64'(eoh));
      consume(tag);
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      msb_first = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;

      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset found", 64'(found), 64'd0);
      chk("reset idx", 64'(idx), 64'd0);
      chk("reset onehot", 64'(onehot), 64'd0);

      run("lsb bit0", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 5'd0, 32'h0000_0001, 1);
      run("lsb bit23", 32'hFFFF_0000, 32'hFF7F_0000, 1'b0, 1'b1, 5'd23, 32'h0080_0000, 3);
      run("msb bit23", 32'hFFFF_0000, 32'hFF7F_0000, 1'b1, 1'b1, 5'd23, 32'h0080_0000, 2);
      run("lsb miss", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 4);
      run("msb miss", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 32'h0000_0000, 4);
      run("lsb ends", 32'h8000_0001, 32'h0000_0000, 1'b0, 1'b1, 5'd0, 32'h0000_0001, 1);
      run("msb ends", 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 1);

      // Backpressure: result must hold while the consumer stalls.
      send("bp", 32'h0000_0000, 32'h0000_0010, 1'b0);
      wait_out(lat);
      chk("bp latency", 64'(lat), 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp out_valid held", 64'(out_valid), 64'd1);
         chk("bp in_ready low", 64'(in_ready), 64'd0);
         chk("bp found held", 64'(found), 64'd1);
         chk("bp idx held", 64'(idx), 64'd4);
         chk("bp onehot held", 64'(onehot), 64'h0000_0010);
      end
      consume("bp");
      run("bp second", 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 1);

      // Reset in the middle of a miss scan discards the request.
      send("midrst", 32'h1234_5678, 32'h1234_5678, 1'b0);
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst out_valid", 64'(out_valid), 64'd0);
      chk("midrst in_ready", 64'(in_ready), 64'd1);
      chk("midrst found", 64'(found), 64'd0);
      chk("midrst idx", 64'(idx), 64'd0);
      chk("midrst onehot", 64'(onehot), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midrst no stale out_valid", 64'(out_valid), 64'd0);
      end
      run("post reset", 32'h0000_0000, 32'h0001_0000, 1'b0, 1'b1, 5'd16, 32'h0001_0000, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
